ahb3lite_sram_ws: RTL and testbench

//  AHB3-Lite SRAM slave with programmable wait states, byte/halfword/word lane writes and ERROR response.

---
 rtl/ahb3lite_sram_ws_if.sv | 29 ++
 rtl/ahb3lite_sram_ws.sv | 179 +++++++++++++++++
 tb/tb_ahb3lite_sram_ws.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb3lite_sram_ws_if.sv
// AHB3-Lite slave-side bus bundle shared by the SRAM slave and its bench.
// The decoder, mux and master own the master modport; the slave drives the response signals.
interface ahb3lite_sram_ws_if #(
  parameter int HADDR_SIZE = 32,
  parameter int HDATA_SIZE = 32
);
  logic                  HSEL;
  logic [HADDR_SIZE-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [2:0]            HBURST;
  logic [3:0]            HPROT;
  logic [HDATA_SIZE-1:0] HWDATA;
  logic                  HREADY;
  logic [HDATA_SIZE-1:0] HRDATA;
  logic                  HREADYOUT;
  logic                  HRESP;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    input  HRDATA, HREADYOUT, HRESP
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA, HREADY,
    output HRDATA, HREADYOUT, HRESP
  );
endinterface

// File: rtl/ahb3lite_sram_ws.sv
// AHB3-Lite SRAM slave with programmable wait states, byte-lane writes and a two-cycle ERROR response.
// All bus outputs are registered and decoded from the next FSM state.
module ahb3lite_sram_ws #(
  parameter int MEM_SIZE    = 256,
  parameter int HADDR_SIZE  = 32,
  parameter int HDATA_SIZE  = 32,
  parameter int WAIT_STATES = 0
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahb3lite_sram_ws_if.slave   bus
);

  localparam int NB        = HDATA_SIZE / 8;
  localparam int LANE_BITS = $clog2(NB);
  localparam int AW        = $clog2(MEM_SIZE);
  localparam int WORDS     = MEM_SIZE / NB;
  localparam int IDX_W     = (AW > LANE_BITS) ? (AW - LANE_BITS) : 1;
  localparam logic [2:0] CNT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  function automatic logic [IDX_W-1:0] word_idx(input logic [HADDR_SIZE-1:0] addr);
    return IDX_W'(addr[AW-1:0] >> LANE_BITS);
  endfunction

  function automatic logic [NB-1:0] lane_mask(input logic [HADDR_SIZE-1:0] addr,
                                              input logic [2:0]            size);
    logic [NB-1:0] mask;
    int            off;
    int            len;
    off = int'(addr[AW-1:0]) % NB;
    len = 32'sd1 << size;
    for (int i = 0; i < NB; i++) begin
      mask[i] = (i >= off) && (i < off + len);
    end
    return mask;
  endfunction

  function automatic logic is_error(input logic [HADDR_SIZE-1:0] addr,
                                    input logic [2:0]            size);
    logic oor;
    logic big;
    logic mis;
    oor = (addr >= HADDR_SIZE'(MEM_SIZE));
    big = (int'(size) > LANE_BITS);
    mis = ((int'(addr[AW-1:0]) & ((32'sd1 << size) - 32'sd1)) != 32'sd0);
    return oor | big | mis;
  endfunction

  logic [HDATA_SIZE-1:0] mem_r [WORDS];

  state_t                state_r;
  state_t                state_nxt_s;
  logic [2:0]            cnt_r;
  logic [2:0]            cnt_nxt_s;
  logic [IDX_W-1:0]      idx_r;
  logic [NB-1:0]         be_r;
  logic                  write_r;
  logic                  hreadyout_r;
  logic                  hresp_r;
  logic [HDATA_SIZE-1:0] hrdata_r;

  logic                  accept_s;
  logic                  err_s;
  logic                  load_s;
  logic                  wr_commit_s;
  logic                  rd_next_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic [HDATA_SIZE-1:0] merged_s;
  logic [HDATA_SIZE-1:0] hrdata_nxt_s;
  logic                  unused_s;

  assign accept_s    = bus.HSEL & bus.HREADY & bus.HTRANS[1];
  assign err_s       = is_error(bus.HADDR, bus.HSIZE);
  assign wr_commit_s = (state_r == ST_DATA) & write_r;
  assign unused_s    = ^{bus.HBURST, bus.HPROT, bus.HTRANS[0]};

  assign bus.HRDATA    = hrdata_r;
  assign bus.HREADYOUT = hreadyout_r;
  assign bus.HRESP     = hresp_r;

  // Next-state decode; IDLE, DATA and ERR2 are the cycles where a new address phase may be taken
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    load_s      = 1'b0;
    case (state_r)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          load_s = 1'b1;
          if (err_s) begin
            state_nxt_s = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_nxt_s = ST_WAIT;
            cnt_nxt_s   = CNT_INIT;
          end else begin
            state_nxt_s = ST_DATA;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 3'd0) begin
          state_nxt_s = ST_DATA;
        end else begin
          cnt_nxt_s = cnt_r - 3'd1;
        end
      end
      ST_ERR1: begin
        state_nxt_s = ST_ERR2;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Write data merged into the addressed word, lane by lane
  always_comb begin
    merged_s = mem_r[idx_r];
    for (int i = 0; i < NB; i++) begin
      merged_s[8*i +: 8] = be_r[i] ? bus.HWDATA[8*i +: 8] : mem_r[idx_r][8*i +: 8];
    end
  end

  // Read data for the upcoming completion cycle; forwards a write committing at the same edge
  always_comb begin
    rd_idx_s  = load_s ? word_idx(bus.HADDR) : idx_r;
    rd_next_s = (state_nxt_s == ST_DATA) & ~(load_s ? bus.HWRITE : write_r);
    if (!rd_next_s) begin
      hrdata_nxt_s = '0;
    end else if (wr_commit_s && (rd_idx_s == idx_r)) begin
      hrdata_nxt_s = merged_s;
    end else begin
      hrdata_nxt_s = mem_r[rd_idx_s];
    end
  end

  // FSM state, captured address phase and registered bus response
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 3'd0;
      idx_r       <= '0;
      be_r        <= '0;
      write_r     <= 1'b0;
      hreadyout_r <= 1'b1;
      hresp_r     <= 1'b0;
      hrdata_r    <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (load_s) begin
        idx_r   <= word_idx(bus.HADDR);
        be_r    <= lane_mask(bus.HADDR, bus.HSIZE);
        write_r <= bus.HWRITE & ~err_s;
      end
      hreadyout_r <= ~((state_nxt_s == ST_WAIT) | (state_nxt_s == ST_ERR1));
      hresp_r     <= (state_nxt_s == ST_ERR1) | (state_nxt_s == ST_ERR2);
      hrdata_r    <= hrdata_nxt_s;
    end
  end

  // Storage array; contents survive reset
  always_ff @(posedge HCLK) begin
    if (wr_commit_s) begin
      mem_r[idx_r] <= merged_s;
    end
  end

endmodule

// File: tb/tb_ahb3lite_sram_ws.sv
// Scoreboard bench for ahb3lite_sram_ws: three slaves (0, 2 and 3 wait states) share one pipelined driver,
// expectations come from a byte-level reference memory per slave.
module tb_ahb3lite_sram_ws;

  typedef struct {
    logic [1:0]  trans;
    logic        sel;
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic        abort;
  } stim_t;

  typedef struct {
    logic        rd;
    logic [31:0] rdata;
    logic        resp;
    int          waits;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int          dut_sel;
  logic        hsel_b;
  logic [31:0] haddr_b;
  logic [1:0]  htrans_b;
  logic        hwrite_b;
  logic [2:0]  hsize_b;
  logic [31:0] hwdata_b;
  logic        cur_ready;
  logic        cur_resp;
  logic [31:0] cur_rdata;

  int          n_total;
  int          n_bad;
  stim_t       stim_q[$];
  exp_t        exp_q[$];
  logic [7:0]  model [3][256];

  ahb3lite_sram_ws_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus0 ();
  ahb3lite_sram_ws_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus1 ();
  ahb3lite_sram_ws_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus2 ();

  ahb3lite_sram_ws #(.MEM_SIZE(256), .HADDR_SIZE(32), .HDATA_SIZE(32), .WAIT_STATES(0))
    u_dut0 (.HCLK(clk), .HRESETn(rst_n), .bus(bus0.slave));
  ahb3lite_sram_ws #(.MEM_SIZE(256), .HADDR_SIZE(32), .HDATA_SIZE(32), .WAIT_STATES(2))
    u_dut1 (.HCLK(clk), .HRESETn(rst_n), .bus(bus1.slave));
  ahb3lite_sram_ws #(.MEM_SIZE(256), .HADDR_SIZE(32), .HDATA_SIZE(32), .WAIT_STATES(3))
    u_dut2 (.HCLK(clk), .HRESETn(rst_n), .bus(bus2.slave));

  assign bus0.HSEL = hsel_b & (dut_sel == 0);
  assign bus1.HSEL = hsel_b & (dut_sel == 1);
  assign bus2.HSEL = hsel_b & (dut_sel == 2);
  assign bus0.HADDR = haddr_b;   assign bus1.HADDR = haddr_b;   assign bus2.HADDR = haddr_b;
  assign bus0.HTRANS = htrans_b; assign bus1.HTRANS = htrans_b; assign bus2.HTRANS = htrans_b;
  assign bus0.HWRITE = hwrite_b; assign bus1.HWRITE = hwrite_b; assign bus2.HWRITE = hwrite_b;
  assign bus0.HSIZE = hsize_b;   assign bus1.HSIZE = hsize_b;   assign bus2.HSIZE = hsize_b;
  assign bus0.HWDATA = hwdata_b; assign bus1.HWDATA = hwdata_b; assign bus2.HWDATA = hwdata_b;
  assign bus0.HBURST = 3'd0;     assign bus1.HBURST = 3'd0;     assign bus2.HBURST = 3'd0;
  assign bus0.HPROT = 4'd3;      assign bus1.HPROT = 4'd3;      assign bus2.HPROT = 4'd3;
  assign bus0.HREADY = bus0.HREADYOUT;
  assign bus1.HREADY = bus1.HREADYOUT;
  assign bus2.HREADY = bus2.HREADYOUT;

  // Response mux of the slave currently under test
  always_comb begin
    case (dut_sel)
      0: begin cur_ready = bus0.HREADYOUT; cur_resp = bus0.HRESP; cur_rdata = bus0.HRDATA; end
      1: begin cur_ready = bus1.HREADYOUT; cur_resp = bus1.HRESP; cur_rdata = bus1.HRDATA; end
      default: begin cur_ready = bus2.HREADYOUT; cur_resp = bus2.HRESP; cur_rdata = bus2.HRDATA; end
    endcase
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (slave %0d, t=%0t)", tag, obs, exp, dut_sel, $time);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : ((d == 1) ? 2 : 3);
  endfunction

  task automatic add(input logic [1:0] tr, input logic sel, input logic wr, input logic [31:0] a,
                     input logic [2:0] sz, input logic [31:0] wd, input logic ab);
    stim_t s;
    s.trans = tr; s.sel = sel; s.wr = wr; s.addr = a; s.size = sz; s.wdata = wd; s.abort = ab;
    stim_q.push_back(s);
  endtask

  task automatic wr_item(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    add(2'b10, 1'b1, 1'b1, a, sz, wd, 1'b0);
  endtask

  task automatic rd_item(input logic [31:0] a, input logic [2:0] sz);
    add(2'b10, 1'b1, 1'b0, a, sz, 32'h0, 1'b0);
  endtask

  // Reference decision for one accepted address phase; updates the model for good writes
  task automatic push_exp(input stim_t s);
    exp_t e;
    logic err;
    int   b;
    int   lane;
    e.rd = 1'b0; e.rdata = 32'h0; e.resp = 1'b0; e.waits = 0;
    if (s.sel && s.trans[1]) begin
      err = (s.addr >= 32'd256) || (s.size > 3'd2) ||
            ((s.addr & ((32'd1 << s.size) - 32'd1)) != 32'd0);
      if (err) begin
        e.resp  = 1'b1;
        e.waits = 1;
      end else begin
        e.waits = ws_of(dut_sel);
        b = int'(s.addr[7:2]) * 4;
        if (!s.wr) begin
          e.rd    = 1'b1;
          e.rdata = {model[dut_sel][b+3], model[dut_sel][b+2], model[dut_sel][b+1], model[dut_sel][b]};
        end else if (!s.abort) begin
          for (int j = 0; j < (1 << s.size); j++) begin
            lane = int'(s.addr[1:0]) + j;
            model[dut_sel][int'(s.addr[7:0]) + j] = s.wdata[8*lane +: 8];
          end
        end
      end
    end
    exp_q.push_back(e);
  endtask

  // Pipelined driver: address phase of the queue head overlaps the data phase of the previous item
  task automatic run_stim();
    stim_t a;
    stim_t dp;
    exp_t  e;
    bit    a_valid;
    bit    dp_valid;
    bit    aborted;
    bit    rdy;
    int    waits;
    int    budget;
    dp_valid = 1'b0; aborted = 1'b0; waits = 0; budget = 400;
    while ((stim_q.size() > 0 || dp_valid) && budget > 0) begin
      budget--;
      a_valid = (stim_q.size() > 0);
      if (a_valid) a = stim_q[0];
      hsel_b   = a_valid ? a.sel   : 1'b0;
      htrans_b = a_valid ? a.trans : 2'b00;
      hwrite_b = a_valid ? a.wr    : 1'b0;
      haddr_b  = a_valid ? a.addr  : 32'h0;
      hsize_b  = a_valid ? a.size  : 3'd0;
      hwdata_b = dp_valid ? dp.wdata : 32'h0;
      @(negedge clk);
      rdy = cur_ready;
      if (dp_valid) begin
        e = exp_q[0];
        if (rdy) begin
          void'(exp_q.pop_front());
          chk("waits", 32'(waits), 32'(e.waits));
          chk("resp", {31'd0, cur_resp}, {31'd0, e.resp});
          chk(e.rd ? "rdata" : "rdata_zero", cur_rdata, e.rdata);
          dp_valid = 1'b0;
          waits = 0;
        end else begin
          waits++;
          chk("wait_resp", {31'd0, cur_resp}, {31'd0, e.resp});
          chk("wait_rdata", cur_rdata, 32'h0);
          if (dp.abort && waits == 2) begin
            rst_n = 1'b0;
            #1;
            chk("rst_ready", {31'd0, cur_ready}, 32'd1);
            chk("rst_resp", {31'd0, cur_resp}, 32'd0);
            chk("rst_rdata", cur_rdata, 32'h0);
            void'(exp_q.pop_front());
            stim_q.delete();
            dp_valid = 1'b0;
            aborted  = 1'b1;
            waits = 0;
            htrans_b = 2'b00;
            hsel_b   = 1'b0;
          end
        end
      end else begin
        chk("idle_ready", {31'd0, rdy}, 32'd1);
        chk("idle_resp", {31'd0, cur_resp}, 32'd0);
      end
      @(posedge clk);
      if (a_valid && rdy && !aborted) begin
        void'(stim_q.pop_front());
        dp = a;
        dp_valid = 1'b1;
        push_exp(a);
      end
      #1;
      if (aborted) rst_n = 1'b1;
    end
    if (budget == 0) chk("cycle_budget", 32'd0, 32'd1);
  endtask

  initial begin
    #60000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_total = 0; n_bad = 0; dut_sel = 0;
    hsel_b = 1'b0; haddr_b = 32'h0; htrans_b = 2'b00; hwrite_b = 1'b0; hsize_b = 3'd0; hwdata_b = 32'h0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    for (int d = 0; d < 3; d++) begin
      dut_sel = d;
      #1;
      chk("reset_ready", {31'd0, cur_ready}, 32'd1);
      chk("reset_resp", {31'd0, cur_resp}, 32'd0);
      chk("reset_rdata", cur_rdata, 32'h0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // zero wait states: write/read pipelining, lanes, errors, non-transfers
    dut_sel = 0;
    wr_item(32'h0, 3'd2, 32'hDEADBEEF);
    rd_item(32'h0, 3'd2);
    wr_item(32'h4, 3'd2, 32'h11223344);
    wr_item(32'h6, 3'd0, 32'h00AA0000);
    rd_item(32'h4, 3'd2);
    wr_item(32'h8, 3'd2, 32'hA5A5A5A5);
    wr_item(32'hA, 3'd1, 32'hBEEF0000);
    wr_item(32'h9, 3'd0, 32'h00007700);
    rd_item(32'h8, 3'd2);
    wr_item(32'h100, 3'd0, 32'h00000055);
    wr_item(32'h1, 3'd1, 32'h55555555);
    rd_item(32'h0, 3'd2);
    add(2'b00, 1'b1, 1'b1, 32'h0, 3'd2, 32'h0, 1'b0);
    add(2'b01, 1'b1, 1'b1, 32'h0, 3'd2, 32'h0, 1'b0);
    add(2'b10, 1'b0, 1'b1, 32'h0, 3'd2, 32'hFFFFFFFF, 1'b0);
    add(2'b11, 1'b0, 1'b1, 32'h4, 3'd2, 32'hFFFFFFFF, 1'b0);
    rd_item(32'h0, 3'd2);
    rd_item(32'h4, 3'd2);
    rd_item(32'hFC, 3'd3);
    run_stim();

    // two wait states: stretched data phase, held address phase, error on oversized transfer
    dut_sel = 1;
    wr_item(32'h4, 3'd2, 32'h11223344);
    wr_item(32'h6, 3'd0, 32'h00AA0000);
    rd_item(32'h4, 3'd2);
    rd_item(32'h4, 3'd2);
    rd_item(32'h0, 3'd3);
    wr_item(32'hFF, 3'd0, 32'h99000000);
    wr_item(32'hFC, 3'd0, 32'h00000011);
    rd_item(32'hFC, 3'd2);
    run_stim();

    // three wait states: reset during the second wait cycle drops the pending write
    dut_sel = 2;
    wr_item(32'h8, 3'd2, 32'h12345678);
    rd_item(32'h8, 3'd2);
    run_stim();
    add(2'b10, 1'b1, 1'b1, 32'h8, 3'd2, 32'hCAFEF00D, 1'b1);
    run_stim();
    rd_item(32'h8, 3'd2);
    run_stim();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
